// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin burst arbiter sharing one FIFO write port, with
//            full-gated writes and sticky overflow / missing-ack flags.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              xfer_o,
    output logic                            fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]           fifo_data_in_o,
    input  logic                            fifo_full_i,
    input  logic                            fifo_almostfull_i,
    input  logic                            fifo_wr_ack_i,
    input  logic                            fifo_overflow_i,
    output logic                            err_overflow_o,
    output logic                            err_noack_o,
    output logic [$clog2(BURST_LEN+1)-1:0]  beat_cnt_o
);

    localparam int c_pw = $clog2(NUM_REQ);
    localparam int c_cw = $clog2(BURST_LEN + 1);

    localparam logic [0:0]      c_idle      = 1'b0;
    localparam logic [0:0]      c_burst     = 1'b1;
    localparam logic [c_cw-1:0] c_last_beat = c_cw'(BURST_LEN - 1);
    localparam logic [c_pw-1:0] c_last_idx  = c_pw'(NUM_REQ - 1);

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [c_cw-1:0]    beat_cnt_q, beat_cnt_d;
    logic [c_pw-1:0]    rr_ptr_q, rr_ptr_d;
    logic               wr_en_q;
    logic               err_ov_q;
    logic               err_na_q;

    logic               w_active;
    logic               w_burst_end;
    logic [c_pw-1:0]    w_gidx;
    logic [c_pw-1:0]    w_ptr_next;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [NUM_REQ-1:0] arbitrate(input logic [NUM_REQ-1:0] r,
                                                     input logic [c_pw-1:0]    ptr);
        logic [NUM_REQ-1:0] win;
        logic [c_pw:0]      sum;
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (c_pw+1)'(k);
            if (sum >= (c_pw+1)'(NUM_REQ)) begin
                sum = sum - (c_pw+1)'(NUM_REQ);
            end
            if (r[sum[c_pw-1:0]]) begin
                win = '0;
                win[sum[c_pw-1:0]] = 1'b1;
            end
        end
        return win;
    endfunction

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                w_gidx = c_pw'(i);
            end
        end
    end

    assign w_ptr_next = (w_gidx == c_last_idx) ? '0 : w_gidx + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_idle;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            err_ov_q   <= 1'b0;
            err_na_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= fifo_wr_en_o;
            err_ov_q   <= err_ov_q | fifo_overflow_i;
            err_na_q   <= err_na_q | (wr_en_q & ~fifo_wr_ack_i);
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        beat_cnt_d  = beat_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        w_burst_end = 1'b0;
        case (state_q)
            c_idle: begin
                if (|req_i) begin
                    gnt_d      = arbitrate(req_i, rr_ptr_q);
                    state_d    = c_burst;
                    beat_cnt_d = '0;
                end
            end
            c_burst: begin
                w_burst_end = (fifo_wr_en_o && ((beat_cnt_q == c_last_beat) || fifo_almostfull_i))
                              || !w_active;
                if (w_burst_end) begin
                    // Re-arbitrate on the same edge so back-to-back bursts have no bubble.
                    rr_ptr_d   = w_ptr_next;
                    gnt_d      = arbitrate(req_i, w_ptr_next);
                    state_d    = (|gnt_d) ? c_burst : c_idle;
                    beat_cnt_d = '0;
                end else if (fifo_wr_en_o) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = c_idle;
                gnt_d   = '0;
            end
        endcase
    end

    // Output logic
    assign w_active = |(gnt_q & req_i);

    always_comb begin
        fifo_wr_en_o   = w_active & ~fifo_full_i;
        xfer_o         = gnt_q & req_i & {NUM_REQ{fifo_wr_en_o}};
        fifo_data_in_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                fifo_data_in_o = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign gnt_o          = gnt_q;
    assign beat_cnt_o     = beat_cnt_q;
    assign err_overflow_o = err_ov_q;
    assign err_noack_o    = err_na_q;

endmodule
`default_nettype wire
